// File: rtl/serial_adder_fsm_if.sv
// Operand/result bundle for the bit-serial adder: parallel operand load with start,
// registered sum/carry with busy/done status.
interface serial_adder_fsm_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  sum,
    input  carry
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output sum,
    output carry
  );
endinterface

// File: rtl/serial_adder_fsm.sv
// Bit-serial unsigned adder: operands loaded in parallel, summed LSB-first one bit per
// clock through two chained half adders; result and carry-out published in one step.
module serial_adder_fsm #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_adder_fsm_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Only the upper WIDTH-1 result bits need storing; the newest bit goes straight to sum.
  localparam int unsigned PartW = (WIDTH > 1) ? WIDTH - 1 : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PartW-1:0] partial_q, partial_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cflop_q, cflop_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             ha0_s, ha0_c;
  logic             ha1_c;
  logic             bit_s, bit_c;
  logic             last_bit;
  logic [WIDTH-1:0] shifted;

  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full-adder bit built from two half adders plus an OR of their carries.
  always_comb begin
    {ha0_c, ha0_s} = half_add(a_q[0], b_q[0]);
    {ha1_c, bit_s} = half_add(ha0_s, cflop_q);
    bit_c          = ha0_c | ha1_c;
  end

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  if (WIDTH > 1) begin : g_wide
    assign shifted = {bit_s, partial_q};
  end else begin : g_single
    assign shifted = bit_s;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    partial_d = partial_q;
    sum_d     = sum_q;
    cflop_d   = cflop_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d       = bus.a;
          b_d       = bus.b;
          cflop_d   = 1'b0;
          cnt_d     = '0;
          partial_d = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        cflop_d = bit_c;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CntW'(1);
        if (WIDTH > 1) begin
          partial_d = shifted[WIDTH-1:WIDTH-PartW];
        end
        if (last_bit) begin
          sum_d   = shifted;
          carry_d = bit_c;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      partial_q <= '0;
      sum_q     <= '0;
      cflop_q   <= 1'b0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      partial_q <= partial_d;
      sum_q     <= sum_d;
      cflop_q   <= cflop_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.busy  = (state_q == StRun);
  assign bus.done  = (state_q == StDone);
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Bench for serial_adder_fsm at WIDTH 8, 32 and 1: directed cases plus a random sweep
// checked against plain a+b arithmetic and the fixed WIDTH+1 done latency.
module tb_serial_adder_fsm;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  int          sel;
  logic        start_d;
  logic [31:0] a_d;
  logic [31:0] b_d;

  always #5 clk = ~clk;

  serial_adder_fsm_if #(.WIDTH(8))  if8 ();
  serial_adder_fsm_if #(.WIDTH(32)) if32 ();
  serial_adder_fsm_if #(.WIDTH(1))  if1 ();

  assign if8.start  = start_d && (sel == 0);
  assign if8.a      = a_d[7:0];
  assign if8.b      = b_d[7:0];
  assign if32.start = start_d && (sel == 1);
  assign if32.a     = a_d;
  assign if32.b     = b_d;
  assign if1.start  = start_d && (sel == 2);
  assign if1.a      = a_d[0:0];
  assign if1.b      = b_d[0:0];

  serial_adder_fsm #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_adder_fsm #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
  serial_adder_fsm #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(if1.slave));

  logic        busy_m, done_m, carry_m;
  logic [31:0] sum_m;

  always_comb begin
    busy_m  = if8.busy;
    done_m  = if8.done;
    carry_m = if8.carry;
    sum_m   = {24'h0, if8.sum};
    case (sel)
      1: begin
        busy_m  = if32.busy;
        done_m  = if32.done;
        carry_m = if32.carry;
        sum_m   = if32.sum;
      end
      2: begin
        busy_m  = if1.busy;
        done_m  = if1.done;
        carry_m = if1.carry;
        sum_m   = {31'h0, if1.sum};
      end
      default: ;
    endcase
  end

  // Last published result per instance, as the reference sees it.
  logic [31:0] msum   [3];
  logic        mcarry [3];

  function automatic int unsigned wid(input int s);
    return (s == 0) ? 8 : (s == 1) ? 32 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (sel=%0d)", tag, obs, exp, sel);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation on instance s; hold keeps start high and scrambles a/b after acceptance.
  task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input bit detail);
    int unsigned w;
    logic [31:0] mask;
    logic [32:0] full;
    w    = wid(s);
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    full = {1'b0, a & mask} + {1'b0, b & mask};
    sel     = s;
    a_d     = a;
    b_d     = b;
    start_d = 1'b1;
    step();
    if (!hold) start_d = 1'b0;
    for (int c = 1; c <= int'(w); c++) begin
      chk("busy_run", busy_m, 1);
      chk("done_run", done_m, 0);
      if (detail) begin
        chk("sum_hold", sum_m, msum[s]);
        chk("carry_hold", carry_m, mcarry[s]);
      end
      if (hold) begin
        a_d = $urandom;
        b_d = $urandom;
      end
      step();
    end
    msum[s]   = full[31:0] & mask;
    mcarry[s] = full[w];
    chk("done_pulse", done_m, 1);
    chk("busy_done", busy_m, 0);
    chk("sum", sum_m, msum[s]);
    chk("carry", carry_m, mcarry[s]);
    if (hold) begin
      a_d = $urandom;
      b_d = $urandom;
    end
    step();
    chk("done_once", done_m, 0);
    chk("busy_idle", busy_m, 0);
    start_d = 1'b0;
    step();
    chk("no_requeue", busy_m, 0);
    chk("sum_keep", sum_m, msum[s]);
  endtask

  initial begin
    rst     = 1'b1;
    start_d = 1'b0;
    sel     = 0;
    a_d     = '0;
    b_d     = '0;
    for (int s = 0; s < 3; s++) begin
      msum[s]   = '0;
      mcarry[s] = 1'b0;
    end
    step();
    step();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_busy", busy_m, 0);
      chk("rst_done", done_m, 0);
      chk("rst_sum", sum_m, 0);
      chk("rst_carry", carry_m, 0);
    end
    rst = 1'b0;
    step();

    run_op(0, 32'h0F, 32'h01, 1'b0, 1'b1);
    run_op(0, 32'hFF, 32'h01, 1'b0, 1'b1);
    run_op(0, 32'hFF, 32'hFF, 1'b0, 1'b1);
    run_op(0, 32'h00, 32'h00, 1'b0, 1'b1);
    run_op(0, 32'h12, 32'h34, 1'b1, 1'b1);
    chk("sum_12_34", msum[0], 32'h46);

    // Abort mid-run: reset in cycle 4 must clear everything and suppress done.
    sel     = 0;
    a_d     = 32'hAA;
    b_d     = 32'h55;
    start_d = 1'b1;
    step();
    start_d = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("abort_busy", busy_m, 0);
    chk("abort_done", done_m, 0);
    chk("abort_sum", sum_m, 0);
    chk("abort_carry", carry_m, 0);
    for (int s = 0; s < 3; s++) begin
      msum[s]   = '0;
      mcarry[s] = 1'b0;
    end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      chk("abort_no_done", done_m, 0);
    end

    // Reset and start together: reset wins.
    rst     = 1'b1;
    start_d = 1'b1;
    a_d     = 32'hFF;
    b_d     = 32'hFF;
    step();
    chk("rst_start_busy", busy_m, 0);
    rst     = 1'b0;
    start_d = 1'b0;
    step();
    chk("rst_start_idle", busy_m, 0);
    chk("rst_start_sum", sum_m, 0);

    run_op(2, 32'h1, 32'h1, 1'b0, 1'b1);
    run_op(2, 32'h1, 32'h0, 1'b0, 1'b1);
    run_op(2, 32'h0, 32'h0, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) run_op(0, $urandom, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) run_op(1, $urandom, $urandom, 1'b0, 1'b0);
    run_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
